// File: rtl/dram_sbox_lookup_sched_if.sv
// Signal bundle between the AES requester, the S-box lookup scheduler and the
// shared DRAM read controller. The scheduler uses the slave view.
interface dram_sbox_lookup_sched_if;
  logic         req_vld;
  logic         req_rdy;
  logic [127:0] req_data;
  logic         req_tbl;
  logic         abort;
  logic         res_vld;
  logic         res_rdy;
  logic [127:0] res_data;
  logic         res_err;
  logic         busy;
  logic [7:0]   err_cnt;
  logic         dram_en;
  logic         dram_rd_req;
  logic [3:0]   dram_core;
  logic [5:0]   dram_rwl;
  logic [2:0]   dram_demux;
  logic         dram_rd_done;
  logic [7:0]   dram_rd_data;

  modport master (
    output req_vld, req_data, req_tbl, abort, res_rdy, dram_rd_done, dram_rd_data,
    input  req_rdy, res_vld, res_data, res_err, busy, err_cnt,
           dram_en, dram_rd_req, dram_core, dram_rwl, dram_demux
  );

  modport slave (
    input  req_vld, req_data, req_tbl, abort, res_rdy, dram_rd_done, dram_rd_data,
    output req_rdy, res_vld, res_data, res_err, busy, err_cnt,
           dram_en, dram_rd_req, dram_core, dram_rwl, dram_demux
  );
endinterface

// File: rtl/dram_sbox_lookup_sched.sv
// Walks the 16 bytes of an S-box lookup job through DRAM cores 0..15, one read
// at a time, with a per-read timeout and optional recovery gap between reads.
module dram_sbox_lookup_sched #(
  parameter int TIMEOUT = 64,
  parameter int GAP_CYC = 2
) (
  input logic                     CLK,
  input logic                     RST,
  dram_sbox_lookup_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   k;
  logic [7:0]   timer;
  logic [7:0]   gap_cnt;
  logic [7:0]   err_cnt;
  logic         job_err;
  logic         tbl_q;
  logic [127:0] in_buf;
  logic [127:0] out_buf;
  logic [127:0] out_buf_nxt;
  logic [127:0] res_q;
  logic [7:0]   cur_byte;
  logic [7:0]   store_byte;
  logic         accept;
  logic         do_abort;
  logic         last_byte;
  logic         wait_exit;
  logic         gap_exit;
  logic         store_en;
  logic         addr_en;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Byte 0 is the most significant byte of the 128-bit word.
  function automatic logic [7:0] byte_of(input logic [127:0] v, input logic [3:0] idx);
    return v[{~idx, 3'b000} +: 8];
  endfunction

  assign accept     = (state == S_IDLE) && bus.req_vld;
  assign do_abort   = bus.abort && (state != S_IDLE);
  assign cur_byte   = byte_of(in_buf, k);
  assign last_byte  = (k == 4'd15);
  // A done in the final timeout cycle still counts as a good read.
  assign wait_exit  = (state == S_WAIT) &&
                      (bus.dram_rd_done || (timer == 8'(TIMEOUT - 1)));
  assign gap_exit   = (state == S_GAP) && (gap_cnt == 8'(GAP_CYC - 1));
  assign store_en   = wait_exit && !do_abort;
  assign store_byte = bus.dram_rd_done ? bus.dram_rd_data : 8'h00;
  assign addr_en    = (state == S_ISSUE) || (state == S_WAIT) || (state == S_GAP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_exit) begin
          if (GAP_CYC != 0) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = last_byte ? S_DONE : S_ISSUE;
          end
        end
      end
      S_GAP:   if (gap_exit) state_nxt = last_byte ? S_DONE : S_ISSUE;
      S_DONE:  if (bus.res_rdy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (do_abort) state_nxt = S_IDLE;
  end

  always_comb begin
    out_buf_nxt = out_buf;
    if (store_en) out_buf_nxt[{~k, 3'b000} +: 8] = store_byte;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k       <= 4'd0;
      timer   <= 8'd0;
      gap_cnt <= 8'd0;
      job_err <= 1'b0;
      err_cnt <= 8'd0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        k       <= 4'd0;
        job_err <= 1'b0;
      end
      if (state == S_ISSUE) timer <= 8'd0;
      if (state == S_WAIT) begin
        timer   <= timer + 8'd1;
        gap_cnt <= 8'd0;
      end
      if (state == S_GAP) gap_cnt <= gap_cnt + 8'd1;
      if (store_en && !bus.dram_rd_done) begin
        job_err <= 1'b1;
        err_cnt <= sat_inc8(err_cnt);
      end
      if (((state == S_WAIT) || (state == S_GAP)) && (state_nxt == S_ISSUE)) begin
        k <= k + 4'd1;
      end
      // Result is published only when the whole job finishes, so an abort
      // leaves the previous result visible.
      if ((state_nxt == S_DONE) && (state != S_DONE)) res_q <= out_buf_nxt;
      if (((state == S_DONE) && bus.res_rdy) || do_abort) job_err <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      in_buf <= bus.req_data;
      tbl_q  <= bus.req_tbl;
    end
    out_buf <= out_buf_nxt;
  end

  always_comb begin
    bus.req_rdy     = 1'b0;
    bus.res_vld     = 1'b0;
    bus.res_err     = 1'b0;
    bus.dram_en     = 1'b0;
    bus.dram_rd_req = 1'b0;
    case (state)
      S_IDLE:  bus.req_rdy = 1'b1;
      S_ISSUE: begin
        bus.dram_en     = 1'b1;
        bus.dram_rd_req = 1'b1;
      end
      S_WAIT:  bus.dram_en = 1'b1;
      S_GAP:   bus.dram_en = 1'b1;
      S_DONE: begin
        bus.res_vld = 1'b1;
        bus.res_err = job_err;
      end
      default: ;
    endcase
    bus.busy       = (state != S_IDLE);
    bus.dram_core  = addr_en ? k : 4'd0;
    bus.dram_rwl   = addr_en ? cur_byte[7:2] : 6'd0;
    bus.dram_demux = addr_en ? {tbl_q, cur_byte[1:0]} : 3'd0;
  end

  assign bus.res_data = res_q;
  assign bus.err_cnt  = err_cnt;

endmodule

// File: tb/tb_dram_sbox_lookup_sched.sv
// Scoreboard bench for dram_sbox_lookup_sched: a DRAM model answers each read with
// the AES S-box (table 1 = S-box ^ 8'h5A), optionally leaving chosen cores silent.
module tb_dram_sbox_lookup_sched;
  localparam int TIMEOUT = 64;
  localparam int GAP_CYC = 2;
  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_sbox_lookup_sched_if bus();

  dram_sbox_lookup_sched #(.TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           lat;
    int           acc;
    int           nto;
  } exp_t;

  exp_t         sb_q[$];
  int           n_err = 0;
  int           n_chk = 0;
  int           cyc = 0;
  int           exp_err_cnt = 0;
  logic [15:0]  dead_mask = 16'h0;
  logic         stray_en = 1'b0;
  logic         chk_cores = 1'b0;
  int           strobe_cnt = 0;
  int           strobe_base = 0;
  logic [5:0]   first_rwl;
  logic [2:0]   first_demux;
  int           cd = 0;
  logic [7:0]   pend_data;
  logic [127:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] lut(input logic [7:0] b, input logic t);
    return t ? (sbox(b) ^ 8'h5A) : sbox(b);
  endfunction

  // DRAM model: answers in the second WAIT cycle unless the core is dead.
  always @(posedge clk) begin
    #1;
    bus.dram_rd_done = 1'b0;
    bus.dram_rd_data = 8'h00;
    if (rst) begin
      cd = 0;
    end else if (cd != 0) begin
      cd--;
      if (cd == 0) begin
        bus.dram_rd_done = 1'b1;
        bus.dram_rd_data = pend_data;
      end
    end
    if (!rst && bus.dram_rd_req) begin
      if (strobe_cnt == strobe_base) begin
        first_rwl   = bus.dram_rwl;
        first_demux = bus.dram_demux;
      end
      if (chk_cores) chk("strobe_core", 128'(bus.dram_core), 128'(strobe_cnt - strobe_base));
      strobe_cnt++;
      if (!dead_mask[bus.dram_core]) begin
        cd        = 2;
        pend_data = lut({bus.dram_rwl, bus.dram_demux[1:0]}, bus.dram_demux[2]);
      end
      if (stray_en) begin
        bus.dram_rd_done = 1'b1;
        bus.dram_rd_data = 8'hEE;
      end
    end
  end

  task automatic chk_reset_state(input string p);
    chk({p, "_req_rdy"}, 128'(bus.req_rdy), 128'd1);
    chk({p, "_busy"}, 128'(bus.busy), 128'd0);
    chk({p, "_res_vld"}, 128'(bus.res_vld), 128'd0);
    chk({p, "_res_err"}, 128'(bus.res_err), 128'd0);
    chk({p, "_res_data"}, bus.res_data, 128'd0);
    chk({p, "_err_cnt"}, 128'(bus.err_cnt), 128'd0);
    chk({p, "_dram_en"}, 128'(bus.dram_en), 128'd0);
    chk({p, "_rd_req"}, 128'(bus.dram_rd_req), 128'd0);
    chk({p, "_addr"}, 128'({bus.dram_core, bus.dram_rwl, bus.dram_demux}), 128'd0);
  endtask

  task automatic wait_rdy();
    int i = 0;
    while (!bus.req_rdy && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (!bus.req_rdy) chk("tmo_req_rdy", 128'd0, 128'd1);
  endtask

  // Drives one job at a negedge; returns at the negedge of the first ISSUE cycle.
  task automatic start_job(input logic [127:0] d, input logic tbl,
                           input logic [15:0] dead, input bit push);
    exp_t e;
    wait_rdy();
    dead_mask    = dead;
    strobe_base  = strobe_cnt;
    bus.req_data = d;
    bus.req_tbl  = tbl;
    bus.req_vld  = 1'b1;
    if (push) begin
      e.data = '0;
      e.err  = 1'b0;
      e.lat  = 0;
      e.nto  = 0;
      e.acc  = cyc + 1;
      for (int i = 0; i < 16; i++) begin
        if (dead[i]) begin
          e.data[127-8*i -: 8] = 8'h00;
          e.err = 1'b1;
          e.nto++;
          e.lat += 1 + TIMEOUT + GAP_CYC;
        end else begin
          e.data[127-8*i -: 8] = lut(d[127-8*i -: 8], tbl);
          e.lat += 1 + 2 + GAP_CYC;
        end
      end
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.req_vld = 1'b0;
  endtask

  task automatic wait_result(input int hold);
    int   i = 0;
    exp_t e;
    while (!bus.res_vld && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (!bus.res_vld) begin
      chk("tmo_res_vld", 128'd0, 128'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 128'd0, 128'd1);
      return;
    end
    e = sb_q.pop_front();
    last_data = bus.res_data;
    exp_err_cnt = (exp_err_cnt + e.nto > 255) ? 255 : exp_err_cnt + e.nto;
    chk("latency", 128'(cyc - e.acc), 128'(e.lat));
    chk("res_data", bus.res_data, e.data);
    chk("res_err", 128'(bus.res_err), 128'(e.err));
    chk("err_cnt", 128'(bus.err_cnt), 128'(exp_err_cnt));
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      chk("hold_vld", 128'(bus.res_vld), 128'd1);
      chk("hold_data", bus.res_data, e.data);
      chk("hold_rd_req", 128'(bus.dram_rd_req), 128'd0);
      chk("hold_req_rdy", 128'(bus.req_rdy), 128'd0);
    end
    bus.res_rdy = 1'b1;
    chk("req_rdy_in_done", 128'(bus.req_rdy), 128'd0);
    @(negedge clk);
    bus.res_rdy = 1'b0;
    chk("req_rdy_after", 128'(bus.req_rdy), 128'd1);
    chk("res_vld_after", 128'(bus.res_vld), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst          = 1'b1;
    bus.req_vld  = 1'b0;
    bus.req_data = '0;
    bus.req_tbl  = 1'b0;
    bus.abort    = 1'b0;
    bus.res_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);

    // Golden job through the real S-box.
    chk_cores = 1'b1;
    start_job(D1, 1'b0, 16'h0000, 1'b1);
    wait_result(0);
    chk_cores = 1'b0;
    chk("t1_golden", last_data, 128'h638293C3_1BFC33F5_C4EEACEA_4BC12816);
    chk("t1_strobes", 128'(strobe_cnt - strobe_base), 128'd16);
    chk("t1_first_rwl", 128'(first_rwl), 128'd0);
    chk("t1_first_demux", 128'(first_demux), 128'd0);

    // Core 5 dead: byte forced to zero, error flagged and counted.
    start_job(D1, 1'b0, 16'h0020, 1'b1);
    wait_result(0);

    // Abort in the third WAIT cycle of byte 7 (core 7 held silent).
    start_job(D1, 1'b0, 16'h0080, 1'b0);
    i = 0;
    while (!(bus.dram_rd_req && bus.dram_core == 4'd7) && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("t3_reach_byte7", 128'(bus.dram_rd_req && bus.dram_core == 4'd7), 128'd1);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t3_dram_en", 128'(bus.dram_en), 128'd0);
    chk("t3_busy", 128'(bus.busy), 128'd0);
    chk("t3_req_rdy", 128'(bus.req_rdy), 128'd1);
    chk("t3_res_vld", 128'(bus.res_vld), 128'd0);
    chk("t3_res_data_kept", bus.res_data, last_data);
    chk("t3_err_cnt_kept", 128'(bus.err_cnt), 128'(exp_err_cnt));
    start_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, 16'h0000, 1'b1);
    wait_result(0);

    // Consumer stalls for 10 cycles.
    start_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, 16'h0000, 1'b1);
    wait_result(10);

    // Table 1 with byte 0 = A7, stray done held during every ISSUE.
    stray_en = 1'b1;
    start_job({8'hA7, 32'($urandom), 32'($urandom), 32'($urandom), 24'($urandom)},
              1'b1, 16'h0000, 1'b1);
    chk("t6_rd_req", 128'(bus.dram_rd_req), 128'd1);
    chk("t6_rwl", 128'(bus.dram_rwl), 128'h29);
    chk("t6_demux", 128'(bus.dram_demux), 128'd7);
    wait_result(0);
    stray_en = 1'b0;

    // Abort while holding a finished result discards it.
    start_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, 16'h0000, 1'b0);
    i = 0;
    while (!bus.res_vld && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("t7_res_vld_seen", 128'(bus.res_vld), 128'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t7_res_vld_drop", 128'(bus.res_vld), 128'd0);
    chk("t7_req_rdy", 128'(bus.req_rdy), 128'd1);

    // Every core silent until err_cnt saturates.
    for (int j = 0; j < 19; j++) begin
      start_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, 16'hFFFF, 1'b1);
      wait_result(0);
    end
    chk("t5_err_cnt_sat", 128'(bus.err_cnt), 128'd255);

    // Reset in the middle of a job.
    start_job(D1, 1'b0, 16'h0000, 1'b0);
    repeat (20) @(negedge clk);
    chk("t5_busy_before_rst", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;
    exp_err_cnt = 0;
    @(negedge clk);
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
